// File: rtl/stream_mux_nto1.sv
// N-to-1 stream mux with a one-entry registered output; fixed-select or round-robin grant.
// Latency 1 cycle; InReady is combinational in OutReady, so a full register refills while it drains.
module stream_mux_nto1 #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Mode,
    input  logic [SELW-1:0]    Sel,
    input  logic [N*WIDTH-1:0] InData,
    input  logic [N-1:0]       InValid,
    output logic [N-1:0]       InReady,
    output logic [WIDTH-1:0]   OutData,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [SELW-1:0]    OutChan
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SELW-1:0]   chan_q, chan_d;
    logic [SELW-1:0]   ptr_q, ptr_d;

    logic              fx_found;
    logic              rr_found;
    logic [SELW-1:0]   rr_idx;
    logic [SELW:0]     rr_cand;
    logic              gnt_any;
    logic [SELW-1:0]   gnt_idx;
    logic [N-1:0]      gnt_vec;
    logic [WIDTH-1:0]  gnt_data;
    logic              accept;
    logic              load;

    // Fixed mode: an out-of-range Sel matches no channel, so nothing is granted.
    always_comb begin
        fx_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (Sel == SELW'(i) && InValid[i]) begin
                fx_found = 1'b1;
            end
        end
    end

    // Round-robin: scan ptr, ptr+1, ... modulo N and take the first valid channel.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 0; k < N; k++) begin
            rr_cand = {1'b0, ptr_q} + (SELW+1)'(k);
            if (rr_cand >= (SELW+1)'(N)) begin
                rr_cand = rr_cand - (SELW+1)'(N);
            end
            for (int i = 0; i < N; i++) begin
                if (!rr_found && rr_cand == (SELW+1)'(i) && InValid[i]) begin
                    rr_found = 1'b1;
                    rr_idx   = SELW'(i);
                end
            end
        end
    end

    assign gnt_any = Mode ? rr_found : fx_found;
    assign gnt_idx = Mode ? rr_idx   : Sel;

    always_comb begin
        gnt_vec  = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_any && gnt_idx == SELW'(i)) begin
                gnt_vec[i] = 1'b1;
                gnt_data   = InData[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept  = (state_q == S_EMPTY) || OutReady;
    assign load    = accept && gnt_any;
    assign InReady = gnt_vec & {N{accept}};

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_EMPTY: begin
                if (load) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (OutReady && !load) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (load) begin
            data_d = gnt_data;
            chan_d = gnt_idx;
            if (Mode) begin
                ptr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign OutValid = (state_q == S_FULL);
    assign OutData  = data_q;
    assign OutChan  = chan_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench: 4-channel instance for fixed/RR/back-pressure/reset, 3-channel instance for out-of-range Sel.
module tb_stream_mux_nto1;

    logic         Clk;
    logic         Reset;

    logic         Mode;
    logic [1:0]   Sel;
    logic [127:0] InData;
    logic [3:0]   InValid;
    logic [3:0]   InReady;
    logic [31:0]  OutData;
    logic         OutValid;
    logic         OutReady;
    logic [1:0]   OutChan;

    logic         Mode3;
    logic [1:0]   Sel3;
    logic [95:0]  InData3;
    logic [2:0]   InValid3;
    logic [2:0]   InReady3;
    logic [31:0]  OutData3;
    logic         OutValid3;
    logic         OutReady3;
    logic [1:0]   OutChan3;

    int vectors;
    int miscompares;

    stream_mux_nto1 #(.WIDTH(32), .N(4)) u4 (
        .Clk(Clk), .Reset(Reset), .Mode(Mode), .Sel(Sel),
        .InData(InData), .InValid(InValid), .InReady(InReady),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady), .OutChan(OutChan)
    );

    stream_mux_nto1 #(.WIDTH(32), .N(3)) u3 (
        .Clk(Clk), .Reset(Reset), .Mode(Mode3), .Sel(Sel3),
        .InData(InData3), .InValid(InValid3), .InReady(InReady3),
        .OutData(OutData3), .OutValid(OutValid3), .OutReady(OutReady3), .OutChan(OutChan3)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] chdat(input int c);
        case (c)
            0:       chdat = 32'h11110000;
            1:       chdat = 32'h22221111;
            2:       chdat = 32'hDEADBEEF;
            default: chdat = 32'h33332222;
        endcase
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset     = 1'b0;
        Mode      = 1'b0;
        Sel       = 2'd0;
        InData    = {32'h33332222, 32'hDEADBEEF, 32'h22221111, 32'h11110000};
        InValid   = 4'b0000;
        OutReady  = 1'b0;
        Mode3     = 1'b0;
        Sel3      = 2'd0;
        InData3   = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
        InValid3  = 3'b000;
        OutReady3 = 1'b0;

        #1;
        chk("rst_valid", {31'd0, OutValid}, 32'd0);
        chk("rst_data",  OutData, 32'd0);
        chk("rst_chan",  {30'd0, OutChan}, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;

        // Fixed select of channel 2 with every channel valid
        Mode = 1'b0; Sel = 2'd2; InValid = 4'b1111; OutReady = 1'b1;
        #1;
        chk("fix_rdy_pre", {28'd0, InReady}, 32'h4);
        @(negedge Clk);
        chk("fix_valid", {31'd0, OutValid}, 32'd1);
        chk("fix_data",  OutData, 32'hDEADBEEF);
        chk("fix_chan",  {30'd0, OutChan}, 32'd2);
        chk("fix_rdy",   {28'd0, InReady}, 32'h4);

        // Back-pressure for 3 cycles, Sel moved to 1 meanwhile
        OutReady = 1'b0; Sel = 2'd1;
        #1;
        chk("bp_rdy_now", {28'd0, InReady}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            chk("bp_valid", {31'd0, OutValid}, 32'd1);
            chk("bp_data",  OutData, 32'hDEADBEEF);
            chk("bp_chan",  {30'd0, OutChan}, 32'd2);
            chk("bp_rdy",   {28'd0, InReady}, 32'h0);
        end
        OutReady = 1'b1;
        #1;
        chk("bp_release_rdy", {28'd0, InReady}, 32'h2);
        @(negedge Clk);
        chk("bp_new_data", OutData, 32'h22221111);
        chk("bp_new_chan", {30'd0, OutChan}, 32'd1);

        // Round-robin from pointer 0, all valid, no bubbles
        Mode = 1'b1;
        #1;
        chk("rr_first_rdy", {28'd0, InReady}, 32'h1);
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            chk("rr_valid", {31'd0, OutValid}, 32'd1);
            chk("rr_chan",  {30'd0, OutChan}, c % 4);
            chk("rr_data",  OutData, chdat(c % 4));
        end

        // Load channel 2 so the pointer lands on 3, then wrap and skip with 0101
        InValid = 4'b0100;
        @(negedge Clk);
        chk("rr_ch2_chan", {30'd0, OutChan}, 32'd2);
        InValid = 4'b0101;
        #1;
        chk("wrap_rdy0", {28'd0, InReady}, 32'h1);
        @(negedge Clk);
        chk("wrap_chan0", {30'd0, OutChan}, 32'd0);
        chk("wrap_rdy1", {28'd0, InReady}, 32'h4);
        @(negedge Clk);
        chk("wrap_chan1", {30'd0, OutChan}, 32'd2);
        chk("wrap_rdy2", {28'd0, InReady}, 32'h1);
        @(negedge Clk);
        chk("wrap_chan2", {30'd0, OutChan}, 32'd0);
        chk("wrap_data2", OutData, 32'h11110000);

        // Drain to empty
        InValid = 4'b0000;
        @(negedge Clk);
        chk("drain_valid", {31'd0, OutValid}, 32'd0);

        // Asynchronous reset while a word is held under back-pressure
        Mode = 1'b0; Sel = 2'd3; InValid = 4'b1000; OutReady = 1'b0;
        @(negedge Clk);
        chk("hold_valid", {31'd0, OutValid}, 32'd1);
        chk("hold_chan",  {30'd0, OutChan}, 32'd3);
        #1;
        Reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, OutValid}, 32'd0);
        chk("arst_data",  OutData, 32'd0);
        chk("arst_chan",  {30'd0, OutChan}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        Mode = 1'b1; InValid = 4'b1111; OutReady = 1'b1;
        #1;
        chk("arst_ptr_rdy", {28'd0, InReady}, 32'h1);
        @(negedge Clk);
        chk("arst_ptr_chan", {30'd0, OutChan}, 32'd0);
        InValid = 4'b0000;

        // Out-of-range select on the 3-channel instance
        Mode3 = 1'b0; Sel3 = 2'd0; InValid3 = 3'b111; OutReady3 = 1'b0;
        @(negedge Clk);
        chk("n3_load_valid", {31'd0, OutValid3}, 32'd1);
        chk("n3_load_data",  OutData3, 32'hA0A0A0A0);
        Sel3 = 2'd3;
        #1;
        chk("n3_sel3_rdy_bp", {29'd0, InReady3}, 32'h0);
        OutReady3 = 1'b1;
        #1;
        chk("n3_sel3_rdy", {29'd0, InReady3}, 32'h0);
        @(negedge Clk);
        chk("n3_drain_valid", {31'd0, OutValid3}, 32'd0);
        @(negedge Clk);
        chk("n3_idle_valid", {31'd0, OutValid3}, 32'd0);
        chk("n3_idle_rdy",   {29'd0, InReady3}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
